// File: rtl/sample_window_buffer.sv
// rtl/sample_window_buffer.sv - pairs RS232 bytes into samples, streams sliding windows (optional SAMPLE_WIN_DROP_CNT_EN)
module sample_window_buffer #(
    parameter int DEPTH  = 40,
    parameter int HOP    = 8,
    parameter int DATA_W = 16
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_win_start,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_filled,
    output logic [7:0]        o_drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int HOP_W = $clog2(HOP + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALMOST    = CNT_W'(DEPTH - 1);
    localparam logic [HOP_W-1:0] HOP_LAST  = HOP_W'(HOP - 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_START,
        S_STREAM
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  fill_cnt;
    logic [HOP_W-1:0]  hop_cnt;
    logic [7:0]        hi_byte;
    logic              phase_lo;

    logic collecting;
    logic sample_wr;
    logic window_due;
    logic beat_take;

    // Byte acceptance only depends on the state register, so the write path stays acyclic.
    assign collecting = (state == S_COLLECT);
    assign sample_wr  = i_byte_valid && collecting && phase_lo;
    assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign window_due = sample_wr &&
                        ((fill_cnt == ALMOST) || (o_filled && (hop_cnt == HOP_LAST)));
    assign beat_take  = o_valid && i_ready;
    assign o_filled   = (fill_cnt == FULL_CNT);
    assign o_data     = o_valid ? mem[rd_ptr] : '0;

    // State register.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next   = state;
        o_byte_ready = 1'b0;
        o_win_start  = 1'b0;
        o_valid      = 1'b0;
        o_last       = 1'b0;
        case (state)
            S_COLLECT: begin
                o_byte_ready = !avm_rst;
                if (window_due) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                o_win_start = 1'b1;
                state_next  = S_STREAM;
            end
            S_STREAM: begin
                o_valid = 1'b1;
                o_last  = (beat_cnt == LAST_PTR);
                if (i_ready && (beat_cnt == LAST_PTR)) begin
                    state_next = S_COLLECT;
                end
            end
            default: begin
                state_next = S_COLLECT;
            end
        endcase
    end

    // Sample storage; contents are don't-care after reset since fill_cnt gates use.
    always_ff @(posedge avm_clk) begin
        if (sample_wr && !avm_rst) begin
            mem[wr_ptr] <= DATA_W'({hi_byte, i_byte});
        end
    end

    // Byte pairing, write pointer, fill and hop bookkeeping.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            hi_byte  <= '0;
            phase_lo <= 1'b0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            hop_cnt  <= '0;
        end else begin
            if (i_byte_valid && collecting) begin
                phase_lo <= !phase_lo;
                if (!phase_lo) begin
                    hi_byte <= i_byte;
                end
            end
            if (sample_wr) begin
                wr_ptr <= wr_ptr_nxt;
                if (!o_filled) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end else begin
                    hop_cnt <= hop_cnt + 1'b1;
                end
            end
            if (state == S_START) begin
                hop_cnt <= '0;
            end
        end
    end

    // Read pointer and beat counter: latched at window trigger, advanced per handshake.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            rd_ptr   <= '0;
            beat_cnt <= '0;
        end else if (window_due) begin
            rd_ptr   <= wr_ptr_nxt;
            beat_cnt <= '0;
        end else if (beat_take) begin
            rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef SAMPLE_WIN_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Count cycles where the sender offered a byte we could not take; saturates.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            drop_cnt <= '0;
        end else if (i_byte_valid && !o_byte_ready && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = '0;
`endif

endmodule
